multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OPW, 5, opcode width; opcodes decode from bits [4:0], upper bits SHALL be zero for a legal opcode.
REQ-002 Parameter WAIT_LIMIT, 15, max MemReady wait cycles before fault; 0 disables the timeout.
REQ-003 Parameter CW, 4, wait-counter width; SHALL satisfy 2**CW > WAIT_LIMIT.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 OPCODE  input  OPW  instruction opcode from the instruction register, sampled in DECODE.
REQ-007 flagbit  input  1  instruction flag bit, sampled with OPCODE.
REQ-008 MemReady  input  1  memory completes the current access this cycle.
REQ-009 MemRead, MemWrite  output  1 each  memory strobes, held until MemReady.
REQ-010 MemSrc  output  3  address select: 000 PC, 100 SP, 101 SP+1.
REQ-011 IRWrite, PCWrite  output  1 each  instruction-register load; PC <= PC+1.
REQ-012 MaryWrite  output  1  Mary load; MarySrc  output  2  (00 memory, 11 immediate).
REQ-013 ShelleyWrite  output  1  Shelley load; ShelleySrc  output  1  (1 = Mary).
REQ-014 SPWrite  output  1  SP load; SPSrc  output  2  (01 SP-1, 10 SP+1).
REQ-015 RAWrite  output  1  RA load; RASrc  output  1  (0 = memory).
REQ-016 Busy  output  1  high in every state except FETCH with no pending request.
REQ-017 Fault  output  1  sticky illegal-opcode or memory-timeout indication.

Function
REQ-018 States: FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs combinational from state plus latched opcode/flag.
REQ-019 FETCH: MemRead=1, MemSrc=000; on MemReady pulse IRWrite=1, PCWrite=1, go to DECODE; else stay.
REQ-020 DECODE: latch OPCODE and flagbit; legal (00000, 00001, 00100, 00101, 00110) -> EXEC or MEM; any other -> TRAP.
REQ-021 APUT (00000): EXEC one cycle; flag=0 -> MaryWrite=1, MarySrc=11; flag=1 -> ShelleyWrite=1, ShelleySrc=1; then FETCH.
REQ-022 SPUT (00001): MEM with MemWrite=1, MemSrc=100 until MemReady; WB SPWrite=1, SPSrc=01.
REQ-023 SPEK (00100): MEM with MemRead=1, MemSrc=101; WB MaryWrite=1, MarySrc=00; SP unchanged.
REQ-024 SPOP (00101): MEM with MemRead=1, MemSrc=100; WB MaryWrite=1, MarySrc=00, SPWrite=1, SPSrc=10.
REQ-025 RPOP (00110): as SPOP but WB asserts RAWrite=1, RASrc=0 instead of MaryWrite.
REQ-026 WB lasts exactly one cycle, then FETCH; every write strobe is a single-cycle pulse.
REQ-027 Latency with MemReady tied high: APUT 3 cycles, stack ops 4 cycles, fetch to fetch.
REQ-028 MemWrite and MemRead SHALL never be high together; no register write strobe is high during a memory wait.
REQ-029 Wait counter clears on entering FETCH or MEM and increments each cycle without MemReady.
REQ-030 With WAIT_LIMIT>0, counter reaching WAIT_LIMIT without MemReady -> TRAP; MemReady in the same cycle wins.
REQ-031 TRAP: Fault=1, all strobes 0; held until RESET.
REQ-032 OPCODE/flagbit changes outside DECODE SHALL NOT affect the executing instruction.

Reset
REQ-033 RESET high at a clock edge -> state FETCH, wait counter 0, Fault 0, latched opcode 0, all strobes 0 the following cycle.
REQ-034 RESET during MEM or WB abandons the instruction; no WB strobe issues for it.
REQ-035 RESET has priority over every transition, including TRAP exit and MemReady.

Structure
REQ-036 Package cu_pkg holds the state enum, opcode constants, and MemSrc/MarySrc/SPSrc encodings.
REQ-037 One sub-module, cu_wait_timer (parameters WAIT_LIMIT and CW; clear, count, expired), owns the timeout counter.

Verification
REQ-038 MemReady=1, OPCODE=00000, flag=0 -> MaryWrite=1, MarySrc=11 in cycle 3, FETCH in cycle 4.
REQ-039 OPCODE=00101, MemReady=0 for 3 MEM cycles then 1 -> MemRead held 4 cycles, then one WB cycle with MaryWrite=1, SPWrite=1, SPSrc=10.
REQ-040 OPCODE=00001 -> MemWrite=1, MemSrc=100 in MEM; WB SPWrite=1, SPSrc=01; MemRead=0 throughout MEM.
REQ-041 OPCODE=10101 -> TRAP after DECODE, Fault=1 held 20 cycles; RESET -> FETCH, Fault=0.
REQ-042 WAIT_LIMIT=15, MemReady=0 in FETCH -> TRAP after 15 cycles; MemReady=1 on cycle 15 -> DECODE, no fault.
REQ-043 RESET asserted in MEM of RPOP -> no RAWrite pulse, FETCH next cycle.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle control unit.
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OP_APUT = 5'b00000;
  localparam logic [4:0] OP_SPUT = 5'b00001;
  localparam logic [4:0] OP_SPEK = 5'b00100;
  localparam logic [4:0] OP_SPOP = 5'b00101;
  localparam logic [4:0] OP_RPOP = 5'b00110;

  localparam logic [2:0] MEMSRC_PC  = 3'b000;
  localparam logic [2:0] MEMSRC_SP  = 3'b100;
  localparam logic [2:0] MEMSRC_SP1 = 3'b101;

  localparam logic [1:0] MARYSRC_MEM = 2'b00;
  localparam logic [1:0] MARYSRC_IMM = 2'b11;

  localparam logic [1:0] SPSRC_DEC = 2'b01;
  localparam logic [1:0] SPSRC_INC = 2'b10;

  localparam logic SHELLEYSRC_MARY = 1'b1;
  localparam logic RASRC_MEM       = 1'b0;

endpackage

// File: rtl/cu_wait_timer.sv
// Memory-wait timeout counter; expired flags the last allowed idle cycle.
module cu_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CW         = 4
) (
  input  logic CLK,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [CW-1:0] cnt;

  // Saturate so a disabled timeout never wraps into a spurious match.
  always_ff @(posedge CLK) begin
    if (clear)
      cnt <= '0;
    else if (count && (cnt != '1))
      cnt <= cnt + CW'(1);
  end

  assign expired = (WAIT_LIMIT != 0) && count && (cnt == CW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer for a small stack machine: fetch, decode, execute,
// memory access and write-back, with an illegal-opcode / timeout trap.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPW        = 5,
  parameter int WAIT_LIMIT = 15,
  parameter int CW         = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [OPW-1:0] OPCODE,
  input  logic           flagbit,
  input  logic           MemReady,
  output logic           MemRead,
  output logic           MemWrite,
  output logic [2:0]     MemSrc,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           MaryWrite,
  output logic [1:0]     MarySrc,
  output logic           ShelleyWrite,
  output logic           ShelleySrc,
  output logic           SPWrite,
  output logic [1:0]     SPSrc,
  output logic           RAWrite,
  output logic           RASrc,
  output logic           Busy,
  output logic           Fault
);

  // state  | meaning
  // FETCH  | read instruction at PC, load IR and bump PC on MemReady
  // DECODE | latch opcode/flag, dispatch or trap on illegal opcode
  // EXEC   | register-only instruction (APUT), single cycle
  // MEM    | stack memory access, held until MemReady
  // WB     | single-cycle register write-back
  // TRAP   | fault, all strobes low until RESET

  state_t         state, state_next;
  logic [OPW-1:0] op_q;
  logic           flag_q;
  logic           timer_clear, timer_count, timer_expired;
  logic           dec_aput, dec_mem;

  assign dec_aput = (OPCODE == OPW'(OP_APUT));
  assign dec_mem  = (OPCODE == OPW'(OP_SPUT)) || (OPCODE == OPW'(OP_SPEK)) ||
                    (OPCODE == OPW'(OP_SPOP)) || (OPCODE == OPW'(OP_RPOP));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= FETCH;
      op_q   <= '0;
      flag_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) begin
        op_q   <= OPCODE;
        flag_q <= flagbit;
      end
    end
  end

  assign timer_count = ((state == FETCH) || (state == MEM)) && !MemReady;
  assign timer_clear = RESET ||
                       ((state_next != state) && ((state_next == FETCH) || (state_next == MEM)));

  cu_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .CW        (CW)
  ) u_wait_timer (
    .CLK    (CLK),
    .clear  (timer_clear),
    .count  (timer_count),
    .expired(timer_expired)
  );

  always_comb begin
    state_next   = state;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemSrc       = MEMSRC_PC;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    MaryWrite    = 1'b0;
    MarySrc      = MARYSRC_MEM;
    ShelleyWrite = 1'b0;
    ShelleySrc   = 1'b0;
    SPWrite      = 1'b0;
    SPSrc        = 2'b00;
    RAWrite      = 1'b0;
    RASrc        = RASRC_MEM;

    case (state)
      FETCH: begin
        MemRead = 1'b1;
        MemSrc  = MEMSRC_PC;
        if (MemReady) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = DECODE;
        end else if (timer_expired) begin
          state_next = TRAP;
        end
      end
      DECODE: begin
        if (dec_aput)
          state_next = EXEC;
        else if (dec_mem)
          state_next = MEM;
        else
          state_next = TRAP;
      end
      EXEC: begin
        if (!flag_q) begin
          MaryWrite = 1'b1;
          MarySrc   = MARYSRC_IMM;
        end else begin
          ShelleyWrite = 1'b1;
          ShelleySrc   = SHELLEYSRC_MARY;
        end
        state_next = FETCH;
      end
      MEM: begin
        if (op_q == OPW'(OP_SPUT)) begin
          MemWrite = 1'b1;
          MemSrc   = MEMSRC_SP;
        end else begin
          MemRead = 1'b1;
          MemSrc  = (op_q == OPW'(OP_SPEK)) ? MEMSRC_SP1 : MEMSRC_SP;
        end
        if (MemReady)
          state_next = WB;
        else if (timer_expired)
          state_next = TRAP;
      end
      WB: begin
        if (op_q == OPW'(OP_SPUT)) begin
          SPWrite = 1'b1;
          SPSrc   = SPSRC_DEC;
        end else if (op_q == OPW'(OP_SPEK)) begin
          MaryWrite = 1'b1;
          MarySrc   = MARYSRC_MEM;
        end else if (op_q == OPW'(OP_SPOP)) begin
          MaryWrite = 1'b1;
          MarySrc   = MARYSRC_MEM;
          SPWrite   = 1'b1;
          SPSrc     = SPSRC_INC;
        end else if (op_q == OPW'(OP_RPOP)) begin
          RAWrite = 1'b1;
          RASrc   = RASRC_MEM;
          SPWrite = 1'b1;
          SPSrc   = SPSRC_INC;
        end
        state_next = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase

    // An instruction being reset is abandoned, so none of its strobes may escape.
    if (RESET) begin
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      MaryWrite    = 1'b0;
      ShelleyWrite = 1'b0;
      SPWrite      = 1'b0;
      RAWrite      = 1'b0;
    end
  end

  assign Busy  = (state != FETCH);
  assign Fault = (state == TRAP);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus pushes the expected per-cycle output vector,
// a monitor on the falling edge pops and compares.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_src;
    logic       ir_write;
    logic       pc_write;
    logic       mary_write;
    logic [1:0] mary_src;
    logic       shelley_write;
    logic       shelley_src;
    logic       sp_write;
    logic [1:0] sp_src;
    logic       ra_write;
    logic       ra_src;
    logic       busy;
    logic       fault;
  } outv_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] OPCODE;
  logic       flagbit;
  logic       MemReady;
  logic       MemRead, MemWrite, IRWrite, PCWrite, MaryWrite, ShelleyWrite;
  logic       ShelleySrc, SPWrite, RAWrite, RASrc, Busy, Fault;
  logic [2:0] MemSrc;
  logic [1:0] MarySrc, SPSrc;

  always #5 CLK = ~CLK;

  multicycle_control_unit #(.OPW(5), .WAIT_LIMIT(15), .CW(4)) dut (
    .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .flagbit(flagbit), .MemReady(MemReady),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSrc(MemSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .MaryWrite(MaryWrite), .MarySrc(MarySrc),
    .ShelleyWrite(ShelleyWrite), .ShelleySrc(ShelleySrc), .SPWrite(SPWrite),
    .SPSrc(SPSrc), .RAWrite(RAWrite), .RASrc(RASrc), .Busy(Busy), .Fault(Fault)
  );

  outv_t act;
  assign act = outv_t'({MemRead, MemWrite, MemSrc, IRWrite, PCWrite, MaryWrite, MarySrc,
                        ShelleyWrite, ShelleySrc, SPWrite, SPSrc, RAWrite, RASrc, Busy, Fault});

  outv_t exp_q[$];
  string nm_q[$];
  int    compared   = 0;
  int    mismatched = 0;

  // Hand-written expected vectors for each observable situation.
  function automatic outv_t e_zero();
    outv_t o;
    o = '0;
    return o;
  endfunction

  function automatic outv_t e_fetch(input bit rdy);
    outv_t o;
    o = '0;
    o.mem_read = 1'b1;
    o.ir_write = rdy;
    o.pc_write = rdy;
    return o;
  endfunction

  function automatic outv_t e_decode();
    outv_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic outv_t e_exec(input bit fl);
    outv_t o;
    o = '0;
    o.busy = 1'b1;
    if (fl) begin
      o.shelley_write = 1'b1;
      o.shelley_src   = 1'b1;
    end else begin
      o.mary_write = 1'b1;
      o.mary_src   = 2'b11;
    end
    return o;
  endfunction

  function automatic outv_t e_mem(input bit wr, input logic [2:0] src);
    outv_t o;
    o = '0;
    o.busy      = 1'b1;
    o.mem_read  = !wr;
    o.mem_write = wr;
    o.mem_src   = src;
    return o;
  endfunction

  function automatic outv_t e_wb(input bit mary, input bit sp, input logic [1:0] sps, input bit ra);
    outv_t o;
    o = '0;
    o.busy       = 1'b1;
    o.mary_write = mary;
    o.sp_write   = sp;
    o.sp_src     = sps;
    o.ra_write   = ra;
    return o;
  endfunction

  function automatic outv_t e_flags(input logic [2:0] src, input bit bsy, input bit flt);
    outv_t o;
    o = '0;
    o.mem_src = src;
    o.busy    = bsy;
    o.fault   = flt;
    return o;
  endfunction

  task automatic cyc(input bit rst, input logic [4:0] op, input bit fl, input bit rdy,
                     input outv_t e, input string nm);
    @(posedge CLK);
    #1;
    RESET    = rst;
    OPCODE   = op;
    flagbit  = fl;
    MemReady = rdy;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Full stack instruction: FETCH, DECODE, MEM (waits idle cycles then ready), WB.
  task automatic stack_op(input logic [4:0] op, input int waits, input outv_t me,
                          input outv_t wb, input string nm);
    cyc(0, 5'b00000, 0, 1, e_fetch(1), {nm, "_fetch"});
    cyc(0, op, 0, 0, e_decode(), {nm, "_decode"});
    for (int i = 0; i < waits; i++)
      cyc(0, 5'b11111, 1, 0, me, {nm, "_memwait"});
    cyc(0, 5'b11111, 1, 1, me, {nm, "_memrdy"});
    cyc(0, 5'b10101, 1, 0, wb, {nm, "_wb"});
  endtask

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        outv_t e;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        compared++;
        if (act !== e) begin
          mismatched++;
          $display("FAIL %s: got %b expected %b", n, act, e);
        end
      end
    end
  end

  initial begin : stimulus
    RESET    = 1'b1;
    OPCODE   = 5'b00000;
    flagbit  = 1'b0;
    MemReady = 1'b0;
    repeat (2) @(posedge CLK);

    cyc(1, 5'b00000, 0, 1, e_zero(), "reset_fetch");

    // APUT flag=0 with a decode-time opcode that changes during EXEC.
    cyc(0, 5'b00000, 0, 1, e_fetch(1), "aput0_fetch");
    cyc(0, 5'b00000, 0, 1, e_decode(), "aput0_decode");
    cyc(0, 5'b11111, 1, 1, e_exec(0), "aput0_exec");
    // APUT flag=1.
    cyc(0, 5'b00000, 0, 1, e_fetch(1), "aput1_fetch");
    cyc(0, 5'b00000, 1, 1, e_decode(), "aput1_decode");
    cyc(0, 5'b00101, 0, 1, e_exec(1), "aput1_exec");

    stack_op(5'b00101, 3, e_mem(0, 3'b100), e_wb(1, 1, 2'b10, 0), "spop");
    stack_op(5'b00001, 1, e_mem(1, 3'b100), e_wb(0, 1, 2'b01, 0), "sput");
    stack_op(5'b00100, 0, e_mem(0, 3'b101), e_wb(1, 0, 2'b00, 0), "spek");
    stack_op(5'b00110, 0, e_mem(0, 3'b100), e_wb(0, 1, 2'b10, 1), "rpop");

    // RESET during MEM of RPOP: strobes suppressed, FETCH next.
    cyc(0, 5'b00000, 0, 1, e_fetch(1), "rpoprst_fetch");
    cyc(0, 5'b00110, 0, 0, e_decode(), "rpoprst_decode");
    cyc(1, 5'b00110, 0, 1, e_flags(3'b100, 1, 0), "rpoprst_mem");
    cyc(0, 5'b00000, 0, 0, e_fetch(0), "rpoprst_after");

    // Fresh FETCH with 14 idle cycles, MemReady on the 15th: no fault.
    cyc(1, 5'b00000, 0, 0, e_zero(), "tmo_ok_reset");
    for (int i = 0; i < 14; i++)
      cyc(0, 5'b00000, 0, 0, e_fetch(0), "tmo_ok_wait");
    cyc(0, 5'b00000, 0, 1, e_fetch(1), "tmo_ok_rdy15");
    cyc(0, 5'b00000, 0, 0, e_decode(), "tmo_ok_decode");
    cyc(0, 5'b00000, 0, 0, e_exec(0), "tmo_ok_exec");

    // FETCH entered from EXEC, 15 idle cycles -> TRAP.
    for (int i = 0; i < 15; i++)
      cyc(0, 5'b00000, 0, 0, e_fetch(0), "tmo_fetch_wait");
    cyc(0, 5'b00000, 0, 1, e_flags(3'b000, 1, 1), "tmo_fetch_trap");
    cyc(0, 5'b00000, 0, 1, e_flags(3'b000, 1, 1), "tmo_fetch_hold");
    cyc(1, 5'b00000, 0, 1, e_flags(3'b000, 1, 1), "tmo_fetch_rst");
    cyc(0, 5'b00000, 0, 0, e_fetch(0), "tmo_fetch_clr");

    // Illegal opcode 10101 traps and holds for 20 cycles.
    cyc(0, 5'b00000, 0, 1, e_fetch(1), "ill_fetch");
    cyc(0, 5'b10101, 0, 1, e_decode(), "ill_decode");
    for (int i = 0; i < 20; i++)
      cyc(0, 5'b00000, i[0], 1, e_flags(3'b000, 1, 1), "ill_trap_hold");
    cyc(1, 5'b00000, 0, 1, e_flags(3'b000, 1, 1), "ill_rst");
    cyc(0, 5'b00000, 0, 0, e_fetch(0), "ill_clr");

    // Another illegal opcode with zero upper bits.
    cyc(1, 5'b00000, 0, 0, e_zero(), "ill2_reset");
    cyc(0, 5'b00000, 0, 1, e_fetch(1), "ill2_fetch");
    cyc(0, 5'b00010, 0, 1, e_decode(), "ill2_decode");
    cyc(0, 5'b00000, 0, 1, e_flags(3'b000, 1, 1), "ill2_trap");

    // MEM timeout on SPEK.
    cyc(1, 5'b00000, 0, 0, e_flags(3'b000, 1, 1), "mtmo_reset");
    cyc(0, 5'b00000, 0, 1, e_fetch(1), "mtmo_fetch");
    cyc(0, 5'b00100, 0, 0, e_decode(), "mtmo_decode");
    for (int i = 0; i < 15; i++)
      cyc(0, 5'b00000, 0, 0, e_mem(0, 3'b101), "mtmo_wait");
    cyc(0, 5'b00000, 0, 1, e_flags(3'b000, 1, 1), "mtmo_trap");
    cyc(1, 5'b00000, 0, 0, e_flags(3'b000, 1, 1), "mtmo_rst");
    cyc(0, 5'b00000, 0, 0, e_fetch(0), "mtmo_clr");

    repeat (2) @(negedge CLK);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
